// File: rtl/mem_req_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the memory controller
// and the arbiter; the arbiter uses the slave view.
interface mem_req_arbiter_if;
   logic        rdy;
   logic        flush;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_inst;
   logic        ls_req;
   logic        ls_wr;
   logic [2:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic        mc_ena;
   logic        mc_wr;
   logic [31:0] mc_addr;
   logic [2:0]  mc_size;
   logic [31:0] mc_wdata;
   logic        mc_ok;
   logic [31:0] mc_rdata;
   logic        busy;

   modport slave (
      input  rdy, flush, if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
             mc_ok, mc_rdata,
      output if_done, if_inst, ls_done, ls_rdata, mc_ena, mc_wr, mc_addr, mc_size,
             mc_wdata, busy
   );

   modport master (
      output rdy, flush, if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
             mc_ok, mc_rdata,
      input  if_done, if_inst, ls_done, ls_rdata, mc_ena, mc_wr, mc_addr, mc_size,
             mc_wdata, busy
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares the single memory-controller port between instruction fetch and
// load/store, one transaction at a time, with a fetch starvation guard.
module mem_req_arbiter #(
   parameter int STARVE_LIMIT = 8
) (
   input logic              clk,
   input logic              rst,
   mem_req_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT    = 2'd2;
   localparam logic [1:0] DISCARD = 2'd3;

   logic [1:0]  state;
   logic        if_pend;
   logic [31:0] if_pend_addr;
   logic        ls_pend;
   logic        ls_pend_wr;
   logic [2:0]  ls_pend_size;
   logic [31:0] ls_pend_addr;
   logic [31:0] ls_pend_wdata;
   logic        cur_ls;
   logic        cur_wr;
   logic        cur_bad;
   logic [3:0]  starve_cnt;
   logic        mc_wr_q;
   logic [31:0] mc_addr_q;
   logic [2:0]  mc_size_q;
   logic [31:0] mc_wdata_q;
   logic        if_done_q;
   logic        ls_done_q;
   logic [31:0] if_inst_q;
   logic [31:0] ls_rdata_q;

   function automatic logic size_ok(input logic [2:0] s);
      return (s == 3'd1) || (s == 3'd2) || (s == 3'd4);
   endfunction

   function automatic logic [31:0] zext_load(input logic [31:0] d, input logic [2:0] s);
      case (s)
         3'd1:    return {24'd0, d[7:0]};
         3'd2:    return {16'd0, d[15:0]};
         default: return d;
      endcase
   endfunction

   logic        if_acc;
   logic        ls_acc;
   logic        if_eff;
   logic        ls_eff;
   logic        grant;
   logic        pick_if;
   logic        rd_flush;
   logic [31:0] sel_if_addr;
   logic        sel_ls_wr;
   logic [2:0]  sel_ls_size;
   logic [31:0] sel_ls_addr;
   logic [31:0] sel_ls_wdata;

   // Bypass: a request arriving in IDLE is arbitrated as if already latched.
   assign if_acc       = bus.if_req && !if_pend && !bus.flush;
   assign ls_acc       = bus.ls_req && !ls_pend && !bus.flush;
   assign if_eff       = if_pend || if_acc;
   assign ls_eff       = ls_pend || ls_acc;
   assign sel_if_addr  = if_pend ? if_pend_addr  : bus.if_addr;
   assign sel_ls_wr    = ls_pend ? ls_pend_wr    : bus.ls_wr;
   assign sel_ls_size  = ls_pend ? ls_pend_size  : bus.ls_size;
   assign sel_ls_addr  = ls_pend ? ls_pend_addr  : bus.ls_addr;
   assign sel_ls_wdata = ls_pend ? ls_pend_wdata : bus.ls_wdata;
   assign grant        = (state == IDLE) && !bus.flush && (if_eff || ls_eff);
   assign pick_if      = if_eff && (!ls_eff || (starve_cnt == 4'(STARVE_LIMIT)));
   // Stores in flight survive a flush; fetches and loads are thrown away.
   assign rd_flush     = bus.flush && !(cur_ls && cur_wr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         if_pend       <= 1'b0;
         if_pend_addr  <= '0;
         ls_pend       <= 1'b0;
         ls_pend_wr    <= 1'b0;
         ls_pend_size  <= '0;
         ls_pend_addr  <= '0;
         ls_pend_wdata <= '0;
         cur_ls        <= 1'b0;
         cur_wr        <= 1'b0;
         cur_bad       <= 1'b0;
         starve_cnt    <= '0;
         mc_wr_q       <= 1'b0;
         mc_addr_q     <= '0;
         mc_size_q     <= '0;
         mc_wdata_q    <= '0;
         if_done_q     <= 1'b0;
         ls_done_q     <= 1'b0;
         if_inst_q     <= '0;
         ls_rdata_q    <= '0;
      end else if (bus.rdy) begin
         if_done_q <= 1'b0;
         ls_done_q <= 1'b0;
         if (if_acc) begin
            if_pend      <= 1'b1;
            if_pend_addr <= bus.if_addr;
         end
         if (ls_acc) begin
            ls_pend       <= 1'b1;
            ls_pend_wr    <= bus.ls_wr;
            ls_pend_size  <= bus.ls_size;
            ls_pend_addr  <= bus.ls_addr;
            ls_pend_wdata <= bus.ls_wdata;
         end
         case (state)
            IDLE: begin
               if (grant) begin
                  state   <= ISSUE;
                  cur_ls  <= !pick_if;
                  cur_wr  <= !pick_if && sel_ls_wr;
                  cur_bad <= !pick_if && !size_ok(sel_ls_size);
                  if (pick_if) begin
                     mc_wr_q    <= 1'b0;
                     mc_addr_q  <= sel_if_addr;
                     mc_size_q  <= 3'd4;
                     mc_wdata_q <= '0;
                  end else if (size_ok(sel_ls_size)) begin
                     mc_wr_q    <= sel_ls_wr;
                     mc_addr_q  <= sel_ls_addr;
                     mc_size_q  <= sel_ls_size;
                     mc_wdata_q <= sel_ls_wdata;
                  end
               end
            end
            ISSUE: begin
               if (cur_ls) ls_pend <= 1'b0;
               else        if_pend <= 1'b0;
               // Illegal sizes never reach the controller; complete locally with zero data.
               if (cur_bad) begin
                  state <= IDLE;
                  if (!rd_flush) begin
                     ls_done_q  <= 1'b1;
                     ls_rdata_q <= '0;
                  end
               end else begin
                  state <= rd_flush ? DISCARD : WAIT;
               end
            end
            WAIT: begin
               if (bus.mc_ok) begin
                  state <= IDLE;
                  if (!rd_flush) begin
                     if (cur_ls) begin
                        ls_done_q <= 1'b1;
                        if (!cur_wr) ls_rdata_q <= zext_load(bus.mc_rdata, mc_size_q);
                     end else begin
                        if_done_q <= 1'b1;
                        if_inst_q <= bus.mc_rdata;
                     end
                  end
               end else if (rd_flush) begin
                  state <= DISCARD;
               end
            end
            default: begin
               if (bus.mc_ok) state <= IDLE;
            end
         endcase
         if (bus.flush) begin
            if_pend <= 1'b0;
            if (!ls_pend_wr) ls_pend <= 1'b0;
         end
         if (bus.flush)
            starve_cnt <= '0;
         else if (grant)
            starve_cnt <= pick_if ? 4'd0 : (if_eff ? starve_cnt + 4'd1 : 4'd0);
         else if (!if_pend)
            starve_cnt <= '0;
      end
   end

   assign bus.mc_ena   = (state == ISSUE) && !cur_bad && bus.rdy;
   assign bus.mc_wr    = mc_wr_q;
   assign bus.mc_addr  = mc_addr_q;
   assign bus.mc_size  = mc_size_q;
   assign bus.mc_wdata = mc_wdata_q;
   assign bus.if_done  = if_done_q && bus.rdy;
   assign bus.ls_done  = ls_done_q && bus.rdy;
   assign bus.if_inst  = if_inst_q;
   assign bus.ls_rdata = ls_rdata_q;
   assign bus.busy     = (state != IDLE) || if_pend || ls_pend;

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Arbitrates the single memory-controller port between the instruction fetcher and the load/store executor. Each requester posts a single-cycle request pulse. The arbiter latches it into a per-requester pending slot, grants the port by priority with a starvation guard, and issues exactly one transaction at a time downstream. On a pipeline flush it cancels or discards reads; stores are never dropped.

## Interface
- STARVE_LIMIT, 8: consecutive load/store grants allowed while a fetch is pending before fetch is forced.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- flush  in  1  pipeline flush pulse
- if_req  in  1  fetch request pulse
- if_addr  in  32  fetch address
- if_done  out  1  fetch complete pulse
- if_inst  out  32  fetched instruction, valid with if_done
- ls_req  in  1  load/store request pulse
- ls_wr  in  1  1 = store, 0 = load
- ls_size  in  3  byte count: 1, 2 or 4
- ls_addr  in  32  load/store address
- ls_wdata  in  32  store data, low bytes used
- ls_done  out  1  load/store complete pulse
- ls_rdata  out  32  load data, zero-extended, valid with ls_done
- mc_ena  out  1  issue pulse to memory controller
- mc_wr  out  1  write flag
- mc_addr  out  32  address
- mc_size  out  3  byte count; 4 for fetch
- mc_wdata  out  32  store data
- mc_ok  in  1  transaction complete pulse from controller
- mc_rdata  in  32  read data, valid with mc_ok
- busy  out  1  state != IDLE or any slot pending

## Operation
- Pending slots:
  - if_pend holds {addr}; ls_pend holds {wr, size, addr, wdata}.
  - A req pulse sets its slot in the same edge.
  - A req arriving while its own slot is pending is ignored; the first request is kept.
- States:
  - IDLE: pick a winner from the pending slots, or from a req arriving this cycle through a bypass that gives the same result as latching first. Then go to ISSUE.
  - ISSUE: drive mc_* from the winner and pulse mc_ena for one cycle. Clear the winner's slot. Go to WAIT.
  - WAIT: on mc_ok, register mc_rdata into if_inst or ls_rdata, pulse the matching done, and go to IDLE.
  - DISCARD: wait for mc_ok, suppress done, and go to IDLE.
- Priority:
  - ls_pend beats if_pend.
  - starve_cnt (4 bits) increments on each ls grant while if_pend is set. It clears on a fetch grant, or when if_pend is clear.
  - When starve_cnt == STARVE_LIMIT and if_pend is set, fetch wins.
- Flush, with precedence over requests arriving the same cycle:
  - Clear if_pend. Clear ls_pend only if it holds a load.
  - Requests arriving in the flush cycle are ignored.
  - In WAIT with a fetch or load in flight: go to DISCARD.
  - In WAIT with a store in flight: stay in WAIT; ls_done is still reported.
  - In ISSUE: the mc_ena pulse still goes out. A read then enters DISCARD instead of WAIT.
  - starve_cnt clears.
- ls_size outside {1, 2, 4}:
  - Nothing is issued downstream.
  - ls_done pulses two cycles after acceptance with ls_rdata = 0.
- rdy low:
  - State, slots and counters hold; mc_ena and done outputs are forced to 0.
  - mc_ok is sampled only when rdy is high.

## Timing
- Reset values:
  - mc_ena, mc_wr, if_done, ls_done, busy = 0.
  - mc_addr, mc_size, mc_wdata, if_inst, ls_rdata = 0.
  - State IDLE, slots empty, starve_cnt = 0.
- Request latency:
  - Req in cycle T with the arbiter in IDLE: ISSUE in T+1 (mc_ena high), WAIT from T+2.
  - mc_ok in cycle K: done pulses in K+1, data is stable in K+1, and state is IDLE in K+1.
  - Back-to-back: the next mc_ena comes earliest at K+2.
- mc_* hold their values from ISSUE until the next ISSUE. mc_ena is high only in ISSUE.
- done outputs are exactly one cycle wide. if_inst and ls_rdata hold until overwritten.
- mc_ok outside WAIT or DISCARD is ignored.

## Test plan
- Single fetch:
  - Stimulus: if_req at addr 0x100; controller returns 0x00A00093 after 5 cycles.
  - Required: mc_ena one cycle after the req with mc_size = 4, mc_wr = 0; if_done one cycle after mc_ok with if_inst = 0x00A00093.
- Simultaneous requests:
  - Stimulus: if_req and ls_req (load, size 2, addr 0x204) in the same cycle; memory returns 0x1234.
  - Required: the load issues first and ls_rdata = 0x00001234; then the fetch issues.
- Starvation:
  - Stimulus: fetch held pending while a new ls_req is posted every time ls_done pulses.
  - Required: the fetch is granted after exactly 8 ls grants; starve_cnt returns to 0.
- Flush during fetch:
  - Stimulus: flush in WAIT of a fetch, with a load pending.
  - Required: state goes to DISCARD; no if_done; the pending load is dropped; busy = 0 after mc_ok.
- Flush during store:
  - Stimulus: flush in WAIT of a store of 0xDEADBEEF, size 4.
  - Required: the store completes; ls_done pulses; a load pending at the time of the flush is dropped.
- Reset and rdy:
  - Stimulus: rst mid-WAIT; separately, rdy low for 3 cycles around mc_ena.
  - Required: all outputs 0 and state IDLE the cycle after rst. With rdy low, mc_ena is delayed by exactly 3 cycles with the same addr.
